// File: rtl/sd_crc16_lanes_if.sv
// Bus bundle for the multi-lane SD CRC16 engine: control/data inputs and CRC/status outputs.
// Names carry the direction as seen from the engine (i_ into it, o_ out of it).
interface sd_crc16_lanes_if #(
  parameter int LANES = 4
);
  logic                   i_clr;
  logic                   i_enable;
  logic [LANES-1:0]       i_bitval;
  logic                   i_start_tx;
  logic                   i_start_chk;
  logic [16*LANES-1:0]    o_crc;
  logic                   o_busy;
  logic [LANES-1:0]       o_ser_out;
  logic                   o_ser_valid;
  logic                   o_tx_done;
  logic                   o_chk_done;
  logic [LANES-1:0]       o_crc_ok;
  logic [1:0]             o_dbg_state;

  // Handshake: i_enable qualifies i_bitval for one bit per cycle while the engine is idle;
  // starts are single-cycle pulses honoured only while o_busy is low, never queued.
  modport master (
    output i_clr, i_enable, i_bitval, i_start_tx, i_start_chk,
    input  o_crc, o_busy, o_ser_out, o_ser_valid, o_tx_done, o_chk_done, o_crc_ok, o_dbg_state
  );

  modport slave (
    input  i_clr, i_enable, i_bitval, i_start_tx, i_start_chk,
    output o_crc, o_busy, o_ser_out, o_ser_valid, o_tx_done, o_chk_done, o_crc_ok, o_dbg_state
  );
endinterface

// File: rtl/sd_crc16_lanes.sv
// Per-lane CRC16 engine for SD DAT lines: accumulates data bits, then serially shifts the CRC
// out (TX) or compares it against an incoming serial CRC (CHK). All lanes share one FSM.
module sd_crc16_lanes #(
  parameter int          LANES = 4,
  parameter logic [15:0] POLY  = 16'h1021,
  parameter logic [15:0] INIT  = 16'h0000
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  sd_crc16_lanes_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TX   = 2'd1,
    S_CHK  = 2'd2
  } state_t;

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [15:0]      r_crc [LANES];
  logic [LANES-1:0] r_mismatch;
  logic [LANES-1:0] r_crc_ok;
  logic             r_tx_done;
  logic             r_chk_done;

  logic [15:0]      w_crc_acc [LANES];
  logic [15:0]      w_crc_shl [LANES];
  logic [LANES-1:0] w_msb;
  logic [LANES-1:0] w_miss;
  logic             w_last;

  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_lane
      assign w_msb[g]     = r_crc[g][15];
      assign w_crc_shl[g] = {r_crc[g][14:0], 1'b0};
      assign w_crc_acc[g] = w_crc_shl[g] ^ ((bus.i_bitval[g] ^ r_crc[g][15]) ? POLY : 16'h0000);
      assign bus.o_crc[16*g +: 16] = r_crc[g];
    end
  endgenerate

  // In CHK the incoming bit is compared with the MSB about to be shifted out.
  assign w_miss = bus.i_bitval ^ w_msb;
  assign w_last = (r_cnt == 4'd15);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_mismatch <= '0;
      r_crc_ok   <= '0;
      r_tx_done  <= 1'b0;
      r_chk_done <= 1'b0;
      for (int i = 0; i < LANES; i++) r_crc[i] <= INIT;
    end else if (bus.i_clr) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_mismatch <= '0;
      r_crc_ok   <= '0;
      r_tx_done  <= 1'b0;
      r_chk_done <= 1'b0;
      for (int i = 0; i < LANES; i++) r_crc[i] <= INIT;
    end else begin
      r_tx_done  <= 1'b0;
      r_chk_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.i_start_tx) begin
            r_state <= S_TX;
            r_cnt   <= 4'd0;
          end else if (bus.i_start_chk) begin
            r_state    <= S_CHK;
            r_cnt      <= 4'd0;
            r_crc_ok   <= '0;
            r_mismatch <= '0;
          end else if (bus.i_enable) begin
            for (int i = 0; i < LANES; i++) r_crc[i] <= w_crc_acc[i];
          end
        end
        S_TX: begin
          r_cnt <= r_cnt + 4'd1;
          if (w_last) begin
            r_state   <= S_IDLE;
            r_tx_done <= 1'b1;
            for (int i = 0; i < LANES; i++) r_crc[i] <= INIT;
          end else begin
            for (int i = 0; i < LANES; i++) r_crc[i] <= w_crc_shl[i];
          end
        end
        S_CHK: begin
          r_cnt      <= r_cnt + 4'd1;
          r_mismatch <= r_mismatch | w_miss;
          if (w_last) begin
            r_state    <= S_IDLE;
            r_chk_done <= 1'b1;
            r_crc_ok   <= ~(r_mismatch | w_miss);
            for (int i = 0; i < LANES; i++) r_crc[i] <= INIT;
          end else begin
            for (int i = 0; i < LANES; i++) r_crc[i] <= w_crc_shl[i];
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign bus.o_busy      = (r_state != S_IDLE);
  assign bus.o_ser_valid = (r_state == S_TX);
  assign bus.o_ser_out   = (r_state == S_TX) ? w_msb : '0;
  assign bus.o_tx_done   = r_tx_done;
  assign bus.o_chk_done  = r_chk_done;
  assign bus.o_crc_ok    = r_crc_ok;
  assign bus.o_dbg_state = r_state;

endmodule

// File: tb/tb_sd_crc16_lanes.sv
// Bench for sd_crc16_lanes: directed cases plus randomized streams against a polynomial-division model.
module tb_sd_crc16_lanes;
  localparam int LANES = 4;
  localparam int MAXB  = 8192;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sd_crc16_lanes_if #(.LANES(LANES)) bus();

  sd_crc16_lanes #(
    .LANES(LANES),
    .POLY (16'h1021),
    .INIT (16'h0000)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // model: message bits per lane since the CRC was last reset
  bit msg [LANES][MAXB];
  int msg_len = 0;
  logic [LANES-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // CRC as the remainder of M(x)*x^16 divided by x^16+x^12+x^5+1 (long division).
  function automatic logic [15:0] model_crc(input int lane);
    logic [16:0] r;
    r = '0;
    for (int k = 0; k < msg_len + 16; k++) begin
      r = {r[15:0], (k < msg_len) ? msg[lane][k] : 1'b0};
      if (r[16]) r = r ^ 17'h11021;
    end
    return r[15:0];
  endfunction

  function automatic logic [16*LANES-1:0] model_all();
    logic [16*LANES-1:0] v;
    for (int i = 0; i < LANES; i++) v[16*i +: 16] = model_crc(i);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // driver tasks
  task automatic accumulate(input logic [LANES-1:0] b);
    bus.i_enable = 1'b1;
    bus.i_bitval = b;
    if (msg_len < MAXB) begin
      for (int i = 0; i < LANES; i++) msg[i][msg_len] = b[i];
      msg_len++;
    end
    tick();
    bus.i_enable = 1'b0;
    bus.i_bitval = '0;
  endtask

  task automatic feed_bytes(input logic [8*LANES-1:0] by, input int n);
    logic [LANES-1:0] b;
    repeat (n) begin
      for (int k = 7; k >= 0; k--) begin
        for (int i = 0; i < LANES; i++) b[i] = by[8*i + k];
        accumulate(b);
      end
    end
  endtask

  task automatic do_clr();
    bus.i_clr = 1'b1;
    tick();
    bus.i_clr = 1'b0;
    msg_len = 0;
    check("clr_crc", bus.o_crc, '0);
  endtask

  task automatic run_tx(input bit both, input bit inject);
    logic [16*LANES-1:0] e;
    logic [LANES-1:0] s;
    e = model_all();
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < LANES; i++) s[i] = e[16*i + 15 - k];
      exp_q.push_back(s);
    end
    bus.i_start_tx  = 1'b1;
    bus.i_start_chk = both;
    tick();
    bus.i_start_tx  = 1'b0;
    bus.i_start_chk = 1'b0;
    msg_len = 0;
    check("tx_start_dones", {bus.o_tx_done, bus.o_chk_done}, 2'b00);
    for (int k = 0; k < 16; k++) begin
      check("tx_valid", bus.o_ser_valid, 1'b1);
      check("tx_busy", bus.o_busy, 1'b1);
      check("tx_ser", bus.o_ser_out, exp_q.pop_front());
      if (inject && k == 3) bus.i_start_chk = 1'b1;
      if (inject && k == 6) begin
        bus.i_enable = 1'b1;
        bus.i_bitval = LANES'($urandom);
      end
      tick();
      bus.i_start_chk = 1'b0;
      bus.i_enable    = 1'b0;
    end
    check("tx_done", bus.o_tx_done, 1'b1);
    check("tx_end_valid", bus.o_ser_valid, 1'b0);
    check("tx_end_busy", bus.o_busy, 1'b0);
    check("tx_end_crc", bus.o_crc, '0);
    check("tx_end_ser", bus.o_ser_out, '0);
  endtask

  task automatic run_chk(input logic [16*LANES-1:0] rx);
    logic [16*LANES-1:0] e;
    logic [LANES-1:0] ok;
    e = model_all();
    for (int i = 0; i < LANES; i++) ok[i] = (rx[16*i +: 16] == e[16*i +: 16]);
    bus.i_start_chk = 1'b1;
    tick();
    bus.i_start_chk = 1'b0;
    msg_len = 0;
    check("chk_start_dones", {bus.o_tx_done, bus.o_chk_done}, 2'b00);
    check("chk_ok_cleared", bus.o_crc_ok, '0);
    check("chk_busy", bus.o_busy, 1'b1);
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < LANES; i++) bus.i_bitval[i] = rx[16*i + 15 - k];
      tick();
    end
    bus.i_bitval = '0;
    check("chk_done", bus.o_chk_done, 1'b1);
    check("chk_crc_ok", bus.o_crc_ok, ok);
    check("chk_end_busy", bus.o_busy, 1'b0);
    check("chk_end_crc", bus.o_crc, '0);
  endtask

  initial begin
    logic [16*LANES-1:0] rx;
    logic [8*LANES-1:0]  by;
    int n;

    bus.i_clr = 1'b0;
    bus.i_enable = 1'b0;
    bus.i_bitval = '0;
    bus.i_start_tx = 1'b0;
    bus.i_start_chk = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_crc", bus.o_crc, '0);
    check("rst_busy", bus.o_busy, 1'b0);
    check("rst_ser", {bus.o_ser_valid, bus.o_ser_out}, '0);
    check("rst_dones", {bus.o_tx_done, bus.o_chk_done}, 2'b00);
    check("rst_ok", bus.o_crc_ok, '0);
    rst_n = 1'b1;
    tick();

    // single bits: a one gives the polynomial, a zero stays at zero
    accumulate(4'b0101);
    check("single_bit", bus.o_crc, 64'h0000_1021_0000_1021);
    accumulate('0);
    check("single_bit_model", bus.o_crc, model_all());
    bus.i_bitval = 4'b1111;
    tick();
    check("enable_low_holds", bus.o_crc, model_all());
    bus.i_bitval = '0;
    do_clr();

    // 512 x 0xFF per lane, then serial TX
    feed_bytes({LANES{8'hFF}}, 512);
    check("ff512_const", bus.o_crc, {LANES{16'h7FA1}});
    check("ff512_model", bus.o_crc, model_all());
    run_tx(1'b0, 1'b0);
    // start a compare in the very cycle TX_DONE is high
    run_chk('0);

    // matching and corrupted compares
    feed_bytes({LANES{8'hFF}}, 512);
    run_chk({LANES{16'h7FA1}});
    check("chk_all_ok", bus.o_crc_ok, 4'b1111);
    feed_bytes({LANES{8'hFF}}, 512);
    rx = {LANES{16'h7FA1}};
    rx[16*2 + 7] = ~rx[16*2 + 7];
    run_chk(rx);
    check("chk_lane2_bad", bus.o_crc_ok, 4'b1011);

    // simultaneous starts, ignored pulses during TX
    for (int j = 0; j < 8; j++) feed_bytes(32'($urandom), 1);
    check("rand8_model", bus.o_crc, model_all());
    run_tx(1'b1, 1'b1);

    // CLR during TX cycle 8
    feed_bytes(32'h1234_5678, 4);
    bus.i_start_tx = 1'b1;
    tick();
    bus.i_start_tx = 1'b0;
    repeat (8) tick();
    bus.i_clr = 1'b1;
    tick();
    bus.i_clr = 1'b0;
    msg_len = 0;
    check("abort_crc", bus.o_crc, '0);
    check("abort_busy", bus.o_busy, 1'b0);
    check("abort_valid", bus.o_ser_valid, 1'b0);
    check("abort_done", bus.o_tx_done, 1'b0);
    check("abort_ok", bus.o_crc_ok, '0);
    tick();
    check("abort_done_later", bus.o_tx_done, 1'b0);

    // asynchronous reset in the middle of a compare
    feed_bytes(32'hA5A5_5A5A, 2);
    run_chk(model_all());
    check("pre_rst_ok", bus.o_crc_ok, 4'b1111);
    feed_bytes(32'h0F0F_F0F0, 2);
    bus.i_start_chk = 1'b1;
    tick();
    bus.i_start_chk = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    msg_len = 0;
    check("arst_crc", bus.o_crc, '0);
    check("arst_busy", bus.o_busy, 1'b0);
    check("arst_ok", bus.o_crc_ok, '0);
    check("arst_dones", {bus.o_tx_done, bus.o_chk_done}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // distinct byte patterns per lane
    feed_bytes({8'h5A, 8'hA5, 8'h00, 8'hFF}, 16);
    check("pattern_model", bus.o_crc, model_all());
    run_tx(1'b0, 1'b0);

    // randomized streams followed by a random TX or a possibly corrupted compare
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 24);
      for (int j = 0; j < n; j++) begin
        for (int i = 0; i < LANES; i++) by[8*i +: 8] = 8'($urandom_range(0, 255));
        feed_bytes(by, 1);
      end
      check("rand_model", bus.o_crc, model_all());
      if ($urandom_range(0, 1) == 1) begin
        run_tx(1'b0, $urandom_range(0, 1) == 1);
      end else begin
        rx = model_all();
        for (int i = 0; i < LANES; i++)
          if ($urandom_range(0, 1) == 1) rx[16*i + $urandom_range(0, 15)] ^= 1'b1;
        run_chk(rx);
      end
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
